// File: rtl/sim_run_controller.sv
// Run controller for the Computer simulation: sequences core reset, counts RUN cycles and
// ends the run on tohost store, PC stall or timeout. Optional self-finish: SIM_RUN_CTRL_FINISH_EN.
module sim_run_controller #(
   parameter int unsigned           RESET_CYCLES   = 4,
   parameter int unsigned           TIMEOUT_CYCLES = 250,
   parameter int unsigned           STALL_LIMIT    = 16,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           CNT_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  core_reset,
   output logic                  running,
   output logic                  done,
   output logic                  pass,
   output logic [2:0]            status,
   output logic [DATA_WIDTH-2:0] fail_code,
   output logic [CNT_WIDTH-1:0]  cycle_count
);

   localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int unsigned STALL_W = $clog2(STALL_LIMIT);

   localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [STALL_W-1:0]   STALL_LAST   = STALL_W'(STALL_LIMIT - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_HALT    = 3'd4,
      S_TIMEOUT = 3'd5
   } state_t;

   state_t                state;
   state_t                run_next;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [STALL_W-1:0]    stall_cnt;
   logic [ADDR_WIDTH-1:0] last_pc;

   logic                  tohost_hit;
   logic                  pc_same;
   logic                  stall_fire;
   logic                  timeout_fire;
   logic [DATA_WIDTH-2:0] store_code;
   logic [CNT_WIDTH-1:0]  cycle_inc;

   assign store_code   = mem_wdata[DATA_WIDTH-1:1];
   assign tohost_hit   = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
   assign pc_same      = (pc == last_pc);
   assign stall_fire   = pc_same && (stall_cnt == STALL_LAST);
   assign timeout_fire = (cycle_count == TIMEOUT_LAST);
   assign cycle_inc    = (&cycle_count) ? cycle_count : cycle_count + CNT_WIDTH'(1);

   // Event priority: tohost store beats stall, stall beats timeout.
   always_comb begin
      run_next = S_RUN;
      if (tohost_hit) begin
         run_next = (store_code == '0) ? S_PASS : S_FAIL;
      end else if (stall_fire) begin
         run_next = S_HALT;
      end else if (timeout_fire) begin
         run_next = S_TIMEOUT;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_HOLD;
         hold_cnt    <= '0;
         stall_cnt   <= '0;
         last_pc     <= '0;
         cycle_count <= '0;
         fail_code   <= '0;
         core_reset  <= 1'b1;
         running     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         status      <= 3'd0;
      end else begin
         case (state)
            S_HOLD: begin
               // last_pc follows pc during HOLD so a pc parked from the start stalls from RUN edge 1.
               last_pc <= pc;
               if (hold_cnt == HOLD_LAST) begin
                  state      <= S_RUN;
                  core_reset <= 1'b0;
                  running    <= 1'b1;
                  status     <= S_RUN;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_RUN: begin
               cycle_count <= cycle_inc;
               last_pc     <= pc;
               if (!pc_same) begin
                  stall_cnt <= '0;
               end else if (!stall_fire) begin
                  stall_cnt <= stall_cnt + STALL_W'(1);
               end
               state  <= run_next;
               status <= run_next;
               if (run_next != S_RUN) begin
                  running <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (run_next == S_PASS);
               end
               if (run_next == S_FAIL) begin
                  fail_code <= store_code;
               end
            end
            default: begin
               // Terminal states hold everything until reset.
            end
         endcase
      end
   end

`ifdef SIM_RUN_CTRL_FINISH_EN
   logic done_d;

   function automatic string status_name(input logic [2:0] code);
      case (code)
         3'd0:    return "HOLD";
         3'd1:    return "RUN";
         3'd2:    return "PASS";
         3'd3:    return "FAIL";
         3'd4:    return "HALT";
         3'd5:    return "TIMEOUT";
         default: return "UNKNOWN";
      endcase
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_d <= 1'b0;
      end else begin
         done_d <= done;
      end
   end

   always @(posedge clock) begin
      if (reset && done && !done_d) begin
         $display("sim_run_controller: %s cycles=%0d fail_code=%0d",
                  status_name(status), cycle_count, fail_code);
         $finish;
      end
   end
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset sequencing, pass/fail stores, stall, priority,
// timeout and mid-run reset, checked with immediate assertions against hand-computed values.
module tb_sim_run_controller;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_reset;
   logic        running;
   logic        done;
   logic        pass;
   logic [2:0]  status;
   logic [30:0] fail_code;
   logic [31:0] cycle_count;

   int vectors     = 0;
   int miscompares = 0;
   bit pc_toggle   = 1'b1;

   sim_run_controller dut (
      .clock       (clock),
      .reset       (reset),
      .pc          (pc),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .core_reset  (core_reset),
      .running     (running),
      .done        (done),
      .pass        (pass),
      .status      (status),
      .fail_code   (fail_code),
      .cycle_count (cycle_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges; sample 1 ns after each edge, then move pc if toggling.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (pc_toggle) pc = pc ^ 32'h4;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      mem_we    = 1'b1;
      mem_addr  = addr;
      mem_wdata = data;
   endtask

   task automatic clear_store();
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
   endtask

   // Called 1 ns after an edge: asserts reset asynchronously, checks, releases, walks HOLD.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check({tag, ".core_reset"}, 64'(core_reset), 64'd1);
      check({tag, ".running"}, 64'(running), 64'd0);
      check({tag, ".done"}, 64'(done), 64'd0);
      check({tag, ".pass"}, 64'(pass), 64'd0);
      check({tag, ".status"}, 64'(status), 64'd0);
      check({tag, ".fail_code"}, 64'(fail_code), 64'd0);
      check({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
      reset = 1'b1;
      step(3);
      check({tag, ".hold3_core_reset"}, 64'(core_reset), 64'd1);
      check({tag, ".hold3_status"}, 64'(status), 64'd0);
      step(1);
      check({tag, ".run_core_reset"}, 64'(core_reset), 64'd0);
      check({tag, ".run_running"}, 64'(running), 64'd1);
      check({tag, ".run_status"}, 64'(status), 64'd1);
      check({tag, ".run_cycle_count"}, 64'(cycle_count), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      pc    = 32'h40;
      clear_store();
      #1;

      do_reset("rst");

      // PASS at RUN cycle 20, then frozen even against a later FAIL store.
      step(20);
      check("pass.pre_count", 64'(cycle_count), 64'd20);
      store(32'h1000, 32'h1);
      step(1);
      clear_store();
      check("pass.status", 64'(status), 64'd2);
      check("pass.pass", 64'(pass), 64'd1);
      check("pass.done", 64'(done), 64'd1);
      check("pass.running", 64'(running), 64'd0);
      check("pass.core_reset", 64'(core_reset), 64'd0);
      check("pass.count", 64'(cycle_count), 64'd21);
      store(32'h1000, 32'h7);
      step(5);
      clear_store();
      check("pass.frozen_status", 64'(status), 64'd2);
      check("pass.frozen_count", 64'(cycle_count), 64'd21);
      check("pass.frozen_fail_code", 64'(fail_code), 64'd0);

      // Bit0=0 store and wrong-address store ignored, then FAIL with code 3.
      do_reset("fail_rst");
      step(3);
      store(32'h1000, 32'h6);
      step(1);
      clear_store();
      check("fail.even_status", 64'(status), 64'd1);
      check("fail.even_count", 64'(cycle_count), 64'd4);
      store(32'h1004, 32'h1);
      step(1);
      clear_store();
      check("fail.addr_status", 64'(status), 64'd1);
      store(32'h1000, 32'h7);
      step(1);
      clear_store();
      check("fail.status", 64'(status), 64'd3);
      check("fail.fail_code", 64'(fail_code), 64'd3);
      check("fail.done", 64'(done), 64'd1);
      check("fail.pass", 64'(pass), 64'd0);
      check("fail.count", 64'(cycle_count), 64'd6);

      // Constant pc: HALT on RUN edge 16.
      pc_toggle = 1'b0;
      pc = 32'h40;
      do_reset("stall_rst");
      step(15);
      check("stall.pre_status", 64'(status), 64'd1);
      check("stall.pre_count", 64'(cycle_count), 64'd15);
      step(1);
      check("stall.status", 64'(status), 64'd4);
      check("stall.done", 64'(done), 64'd1);
      check("stall.count", 64'(cycle_count), 64'd16);

      // Tohost store on the stall edge wins.
      do_reset("prio_rst");
      step(15);
      store(32'h1000, 32'h1);
      step(1);
      clear_store();
      check("prio.status", 64'(status), 64'd2);
      check("prio.pass", 64'(pass), 64'd1);
      check("prio.count", 64'(cycle_count), 64'd16);

      // Toggling pc, no stores: TIMEOUT on RUN edge 250.
      pc_toggle = 1'b1;
      do_reset("to_rst");
      step(249);
      check("timeout.pre_status", 64'(status), 64'd1);
      check("timeout.pre_count", 64'(cycle_count), 64'd249);
      step(1);
      check("timeout.status", 64'(status), 64'd5);
      check("timeout.done", 64'(done), 64'd1);
      check("timeout.running", 64'(running), 64'd0);
      check("timeout.count", 64'(cycle_count), 64'd250);
      step(3);
      check("timeout.frozen_count", 64'(cycle_count), 64'd250);

      // Reset mid-RUN returns to HOLD and the sequence repeats.
      do_reset("mid_pre");
      step(100);
      check("mid.count", 64'(cycle_count), 64'd100);
      do_reset("mid_rst");
      step(10);
      check("mid.after_count", 64'(cycle_count), 64'd10);
      check("mid.after_status", 64'(status), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
